// File: rtl/comparator_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
// Contents: FSM state enum, EQ/LT/GT result struct, digit-count helper.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Exactly one field is set once a compare has completed; all zero before that.
  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_result_t;

  localparam cmp_result_t RES_NONE = '0;

  function automatic int n_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational DIGIT-bit magnitude compare slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluates every cycle.
// Ports: a, b = digit operands; invert_msb = flip MSB of both (offset-binary
//        for the sign digit); eq/lt/gt = relation of a to b.
module digit_cmp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             invert_msb,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

  logic [DIGIT-1:0] a_x;
  logic [DIGIT-1:0] b_x;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_x = a ^ (invert_msb ? MSB_MASK : '0);
  assign b_x = b ^ (invert_msb ? MSB_MASK : '0);

  assign eq = (a_x == b_x);
  assign lt = (a_x <  b_x);
  assign gt = (a_x >  b_x);

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, signed or unsigned.
// Latency: k+1 cycles START->DONE, k = digits examined (N when EARLY_EXIT=0).
// Backpressure: START accepted only while READY (IDLE); otherwise ignored, not queued.
// Ports: CLK/RST_N clock and async active-low reset; START/SIGNED/A/B request;
//        READY idle flag; DONE one-cycle result strobe; EQ/LT/GT held result;
//        CYCLES digits examined for the last result.
module seq_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                                   CLK,
  input  logic                                   RST_N,
  input  logic                                   START,
  input  logic                                   SIGNED,
  input  logic [WIDTH-1:0]                       A,
  input  logic [WIDTH-1:0]                       B,
  output logic                                   READY,
  output logic                                   DONE,
  output logic                                   EQ,
  output logic                                   LT,
  output logic                                   GT,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]       CYCLES
);

  localparam int N  = n_digits(WIDTH, DIGIT);
  localparam int CW = $clog2(N + 1);

  if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
    $error("seq_comparator: DIGIT must be in 1..WIDTH");
  end
  if (WIDTH % DIGIT != 0) begin : g_bad_width
    $error("seq_comparator: WIDTH must be a multiple of DIGIT");
  end

  state_t            state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              signed_q;
  logic [CW-1:0]     cnt_q;
  logic              decided_q;   // an unequal digit has been seen this compare
  logic              dec_lt_q;    // direction of that first unequal digit
  cmp_result_t       res_q;
  logic [CW-1:0]     cycles_q;

  logic [WIDTH-1:0]  a_shift_d, b_shift_d;
  logic [CW-1:0]     cnt_inc_d;
  logic              last_digit_d;
  logic              d_eq, d_lt, d_gt;

  assign a_shift_d    = a_q << DIGIT;
  assign b_shift_d    = b_q << DIGIT;
  assign cnt_inc_d    = cnt_q + CW'(1);
  assign last_digit_d = (cnt_q == CW'(N - 1));

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .a          (a_q[WIDTH-1 -: DIGIT]),
    .b          (b_q[WIDTH-1 -: DIGIT]),
    .invert_msb (signed_q && (cnt_q == '0)),  // sign lives in digit 0 only
    .eq         (d_eq),
    .lt         (d_lt),
    .gt         (d_gt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      dec_lt_q  <= 1'b0;
      res_q     <= RES_NONE;
      cycles_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            a_q       <= A;
            b_q       <= B;
            signed_q  <= SIGNED;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            dec_lt_q  <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_shift_d;
          b_q   <= b_shift_d;
          cnt_q <= cnt_inc_d;
          // Only the first unequal digit decides; later digits are ignored.
          if (!d_eq && !decided_q) begin
            decided_q <= 1'b1;
            dec_lt_q  <= d_lt;
          end
          if (!d_eq && EARLY_EXIT) begin
            res_q    <= '{eq: 1'b0, lt: d_lt, gt: d_gt};
            cycles_q <= cnt_inc_d;
            state_q  <= FIN;
          end else if (last_digit_d) begin
            if (decided_q) res_q <= '{eq: 1'b0, lt: dec_lt_q, gt: !dec_lt_q};
            else           res_q <= '{eq: d_eq, lt: d_lt, gt: d_gt};
            cycles_q <= cnt_inc_d;
            state_q  <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign READY  = (state_q == IDLE);
  assign DONE   = (state_q == FIN);
  assign EQ     = res_q.eq;
  assign LT     = res_q.lt;
  assign GT     = res_q.gt;
  assign CYCLES = cycles_q;

endmodule
